// File: rtl/traffic_light_pkg.sv
// Shared types and constants for the multi-arm junction controller.
// The PED_FLASH state exists only when TRAFFIC_PED_FLASH_EN is defined.
package traffic_light_pkg;

    // Width of one {red, amber, green} lamp field.
    localparam int unsigned LAMP_W = 3;

    localparam logic [LAMP_W-1:0] LAMP_RED   = 3'b100;
    localparam logic [LAMP_W-1:0] LAMP_RA    = 3'b110;
    localparam logic [LAMP_W-1:0] LAMP_GREEN = 3'b001;
    localparam logic [LAMP_W-1:0] LAMP_AMBER = 3'b010;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        RED_AMBER = 3'd1,
        GREEN     = 3'd2,
        AMBER     = 3'd3,
        ALL_RED   = 3'd4,
`ifdef TRAFFIC_PED_FLASH_EN
        PED_WALK  = 3'd5,
        PED_FLASH = 3'd6
`else
        PED_WALK  = 3'd5
`endif
    } state_t;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/phase_timer.sv
// Phase down-counter. Loading value V makes expired rise V cycles later,
// so a phase loaded with TICKS-1 on entry lasts exactly TICKS cycles.
module phase_timer #(
    parameter int unsigned WIDTH = 3
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic             expired
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // Load wins; otherwise count down and hold at zero.
    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_value;
        end else if (count_q != '0) begin
            count_d = count_q - 1'b1;
        end
    end

    // Counter register, cleared asynchronously.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired = (count_q == '0);

endmodule

// File: rtl/traffic_light_junction.sv
// Multi-arm junction controller: rotates right-of-way round NUM_ARMS
// approaches and inserts a pedestrian walk after the all-red that follows
// a request. Define TRAFFIC_PED_FLASH_EN to add a flashing phase after walk.
// Lamp outputs are registered from next-state so they change with the state.
module traffic_light_junction
    import traffic_light_pkg::*;
#(
    parameter int unsigned NUM_ARMS     = 2,
    parameter int unsigned RA_TICKS     = 1,
    parameter int unsigned GREEN_TICKS  = 4,
    parameter int unsigned AMBER_TICKS  = 2,
    parameter int unsigned ALLRED_TICKS = 1,
    parameter int unsigned WALK_TICKS   = 4,
    parameter int unsigned FLASH_TICKS  = 2
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         start,
    input  logic                         ped_request,
    output logic                         ped_wait,
    output logic [LAMP_W*NUM_ARMS+1:0]   lightseq
);

    localparam int unsigned ARM_W     = (NUM_ARMS > 1) ? $clog2(NUM_ARMS) : 1;
    localparam int unsigned MAX_TICKS = max_u(max_u(max_u(RA_TICKS, GREEN_TICKS),
                                                    max_u(AMBER_TICKS, ALLRED_TICKS)),
                                              max_u(WALK_TICKS, FLASH_TICKS));
    localparam int unsigned TW        = $clog2(MAX_TICKS) + 1;
    localparam int unsigned LW        = LAMP_W * NUM_ARMS + 2;
    localparam int unsigned PED_G     = LAMP_W * NUM_ARMS;
    localparam logic [LW-1:0]    LIGHTS_RESET = {2'b10, {NUM_ARMS{LAMP_RED}}};
    localparam logic [ARM_W-1:0] LAST_ARM     = ARM_W'(NUM_ARMS - 1);

    state_t           state_q, state_d;
    logic [ARM_W-1:0] arm_q, arm_d, arm_next;
    logic             pend_q, pend_d;
    logic [LW-1:0]    lights_q, lights_d;
    logic             ped_green_d;
    logic             in_ped;
    logic             timer_load;
    logic [TW-1:0]    timer_value;
    logic             expired;

    assign arm_next = (arm_q == LAST_ARM) ? '0 : arm_q + 1'b1;

`ifdef TRAFFIC_PED_FLASH_EN
    assign in_ped = (state_q == PED_WALK) || (state_q == PED_FLASH);
`else
    assign in_ped = (state_q == PED_WALK);
`endif

    // Next state and active arm.
    always_comb begin
        state_d = state_q;
        arm_d   = arm_q;
        case (state_q)
            IDLE: begin
                if (start) state_d = RED_AMBER;
            end
            RED_AMBER: begin
                if (expired) state_d = GREEN;
            end
            GREEN: begin
                if (expired) state_d = AMBER;
            end
            AMBER: begin
                if (expired) state_d = ALL_RED;
            end
            ALL_RED: begin
                if (expired) begin
                    if (pend_q) begin
                        state_d = PED_WALK;
                    end else begin
                        state_d = RED_AMBER;
                        arm_d   = arm_next;
                    end
                end
            end
            PED_WALK: begin
                if (expired) begin
`ifdef TRAFFIC_PED_FLASH_EN
                    state_d = PED_FLASH;
`else
                    state_d = RED_AMBER;
                    arm_d   = arm_next;
`endif
                end
            end
`ifdef TRAFFIC_PED_FLASH_EN
            PED_FLASH: begin
                if (expired) begin
                    state_d = RED_AMBER;
                    arm_d   = arm_next;
                end
            end
`endif
            default: begin
                state_d = IDLE;
                arm_d   = '0;
            end
        endcase
    end

    // Every transition is a state change, so reload the timer on any change.
    always_comb begin
        timer_load  = (state_d != state_q);
        timer_value = '0;
        case (state_d)
            RED_AMBER: timer_value = TW'(RA_TICKS - 1);
            GREEN:     timer_value = TW'(GREEN_TICKS - 1);
            AMBER:     timer_value = TW'(AMBER_TICKS - 1);
            ALL_RED:   timer_value = TW'(ALLRED_TICKS - 1);
            PED_WALK:  timer_value = TW'(WALK_TICKS - 1);
`ifdef TRAFFIC_PED_FLASH_EN
            PED_FLASH: timer_value = TW'(FLASH_TICKS - 1);
`endif
            default:   timer_value = '0;
        endcase
    end

    // Pending request: set outside pedestrian phases, clear on walk entry (clear wins).
    always_comb begin
        pend_d = pend_q;
        if (ped_request && !in_ped) pend_d = 1'b1;
        if ((state_d == PED_WALK) && (state_q != PED_WALK)) pend_d = 1'b0;
    end

    // Lamp word for the next state; only the active arm leaves red.
    always_comb begin
        lights_d    = LIGHTS_RESET;
        ped_green_d = 1'b0;
        for (int i = 0; i < int'(NUM_ARMS); i++) begin
            if (ARM_W'(i) == arm_d) begin
                case (state_d)
                    RED_AMBER: lights_d[LAMP_W*i +: LAMP_W] = LAMP_RA;
                    GREEN:     lights_d[LAMP_W*i +: LAMP_W] = LAMP_GREEN;
                    AMBER:     lights_d[LAMP_W*i +: LAMP_W] = LAMP_AMBER;
                    default:   lights_d[LAMP_W*i +: LAMP_W] = LAMP_RED;
                endcase
            end
        end
        if (state_d == PED_WALK) begin
            ped_green_d = 1'b1;
`ifdef TRAFFIC_PED_FLASH_EN
        end else if ((state_d == PED_FLASH) && (state_q == PED_FLASH)) begin
            // Flash starts dark on entry, then toggles each cycle.
            ped_green_d = ~lights_q[PED_G];
`endif
        end
        lights_d[PED_G]     = ped_green_d;
        lights_d[PED_G + 1] = ~ped_green_d;
    end

    // State, arm, pending flag and registered lamp outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            arm_q    <= '0;
            pend_q   <= 1'b0;
            lights_q <= LIGHTS_RESET;
        end else begin
            state_q  <= state_d;
            arm_q    <= arm_d;
            pend_q   <= pend_d;
            lights_q <= lights_d;
        end
    end

    phase_timer #(
        .WIDTH (TW)
    ) u_phase_timer (
        .clock      (clock),
        .reset      (reset),
        .load       (timer_load),
        .load_value (timer_value),
        .expired    (expired)
    );

    assign lightseq = lights_q;
    assign ped_wait = pend_q;

endmodule

// File: tb/tb_traffic_light_junction.sv
// Bench for traffic_light_junction: a frame-queue schedule model predicts
// the lamp word and WAIT lamp each cycle; directed steps plus random requests.
// Honours TRAFFIC_PED_FLASH_EN the same way as the design.
module tb_traffic_light_junction;
    import traffic_light_pkg::*;

    localparam int N  = 2;
    localparam int RA = 1;
    localparam int GR = 3;
    localparam int AM = 2;
    localparam int AR = 1;
    localparam int WK = 4;
    localparam int FL = 2;
    localparam int LW = 3 * N + 2;
    localparam logic [LW-1:0] RESET_W = 8'b10_100_100;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          ped_request = 1'b0;
    logic          ped_wait;
    logic [LW-1:0] lightseq;

    traffic_light_junction #(
        .NUM_ARMS     (N),
        .RA_TICKS     (RA),
        .GREEN_TICKS  (GR),
        .AMBER_TICKS  (AM),
        .ALLRED_TICKS (AR),
        .WALK_TICKS   (WK),
        .FLASH_TICKS  (FL)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .ped_request (ped_request),
        .ped_wait    (ped_wait),
        .lightseq    (lightseq)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [LW-1:0] lights;
        bit            is_ped;
    } frame_t;

    // Model: upcoming frames of the current block, the frame on show, and flags.
    frame_t fq[$];
    frame_t cur;
    bit     m_idle;
    bit     m_pend;
    int     m_arm;

    function automatic logic [LW-1:0] word(input int a, input logic [2:0] lamp, input bit pedg);
        logic [LW-1:0] w;
        w = RESET_W;
        w[3*a +: 3] = lamp;
        w[LW-1] = ~pedg;
        w[LW-2] = pedg;
        return w;
    endfunction

    task automatic push(input logic [LW-1:0] w, input bit p, input int n);
        frame_t f;
        f.lights = w;
        f.is_ped = p;
        repeat (n) fq.push_back(f);
    endtask

    task automatic push_car(input int a);
        push(word(a, LAMP_RA, 1'b0), 1'b0, RA);
        push(word(a, LAMP_GREEN, 1'b0), 1'b0, GR);
        push(word(a, LAMP_AMBER, 1'b0), 1'b0, AM);
        push(word(a, LAMP_RED, 1'b0), 1'b0, AR);
    endtask

    task automatic push_ped();
        push(word(0, LAMP_RED, 1'b1), 1'b1, WK);
`ifdef TRAFFIC_PED_FLASH_EN
        for (int k = 0; k < FL; k++) push(word(0, LAMP_RED, (k % 2) == 1), 1'b1, 1);
`endif
    endtask

    task automatic model_reset();
        m_idle = 1'b1;
        m_pend = 1'b0;
        m_arm  = 0;
        fq.delete();
        cur.lights = RESET_W;
        cur.is_ped = 1'b0;
    endtask

    // One clock edge of the schedule: finish a block, then pick the next one.
    task automatic model_edge(input bit s, input bit r);
        bit pn;
        pn = m_pend | (r && !cur.is_ped);
        if (m_idle) begin
            if (s) begin
                m_idle = 1'b0;
                m_arm  = 0;
                push_car(0);
                cur = fq.pop_front();
            end
        end else begin
            if (fq.size() == 0) begin
                if (!cur.is_ped && m_pend) begin
                    push_ped();
                    pn = 1'b0;
                end else begin
                    m_arm = (m_arm + 1) % N;
                    push_car(m_arm);
                end
            end
            cur = fq.pop_front();
        end
        m_pend = pn;
    endtask

    task automatic check(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    // Drive inputs, take one edge, then compare against the model.
    task automatic cyc(input bit s, input bit r);
        start       = s;
        ped_request = r;
        @(posedge clock);
        if (reset) model_edge(s, r);
        #1;
        check("lightseq", lightseq, cur.lights);
        check("ped_wait", LW'(ped_wait), LW'(m_pend));
    endtask

    bit found;

    initial begin
        model_reset();
        #1 reset = 1'b0;
        repeat (5) cyc(1'b0, 1'b0);
        check("reset lights", lightseq, RESET_W);
        check("reset wait", LW'(ped_wait), '0);

        #2 reset = 1'b1;
        repeat (3) cyc(1'b0, 1'b0);
        check("idle hold", lightseq, RESET_W);

        // Full rotation with wrap back to arm 0 at cycle 15.
        cyc(1'b1, 1'b0);
        check("arm0 ra", lightseq, 8'b10_100_110);
        for (int c = 2; c <= 15; c++) begin
            cyc(1'b0, 1'b0);
            if (c == 8)  check("arm1 ra", lightseq, 8'b10_110_100);
            if (c == 15) check("wrap arm0 ra", lightseq, 8'b10_100_110);
        end

        // Request during arm0 green, then walk after all-red.
        cyc(1'b0, 1'b0);
        check("arm0 green", lightseq, 8'b10_100_001);
        cyc(1'b0, 1'b1);
        check("wait set", LW'(ped_wait), LW'(1));
        repeat (4) cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b0);
        check("walk lights", lightseq, 8'b01_100_100);
        check("walk clears wait", LW'(ped_wait), '0);
        cyc(1'b0, 1'b1);
        check("walk ignores req", LW'(ped_wait), '0);
        repeat (2) cyc(1'b0, 1'b0);
`ifdef TRAFFIC_PED_FLASH_EN
        cyc(1'b0, 1'b0);
        check("flash dark", lightseq, 8'b10_100_100);
        cyc(1'b0, 1'b0);
        check("flash lit", lightseq, 8'b01_100_100);
`endif
        cyc(1'b0, 1'b0);
        check("after walk arm1 ra", lightseq, 8'b10_110_100);
        repeat (20) cyc(1'b0, 1'b0);

        // Random requests and start presses.
        repeat (200) cyc(bit'($urandom_range(0, 1)), ($urandom_range(0, 5) == 0));

        // Asynchronous reset in the middle of a green phase.
        found = 1'b0;
        for (int k = 0; k < 40 && !found; k++) begin
            cyc(1'b0, 1'b0);
            for (int a = 0; a < N; a++)
                if (cur.lights[3*a +: 3] == LAMP_GREEN) found = 1'b1;
        end
        check("reached green", LW'(found), LW'(1));
        #2 reset = 1'b0;
        #1;
        check("async reset lights", lightseq, RESET_W);
        check("async reset wait", LW'(ped_wait), '0);
        model_reset();
        cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b1);
        #2 reset = 1'b1;
        cyc(1'b0, 1'b0);
        check("req lost in reset", LW'(ped_wait), '0);
        cyc(1'b1, 1'b0);
        check("restart arm0 ra", lightseq, 8'b10_100_110);
        repeat (30) cyc(1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/traffic_light_junction.md
# traffic_light_junction

Parametrised multi-arm junction controller, the successor to the single-junction traffic light FSM. Cycles right-of-way around `NUM_ARMS` approaches with configurable phase durations and serves a shared pedestrian crossing on demand. It sits directly under the board top level, driving LED/lamp outputs from one system clock, with `start` and `ped_request` taken from debounced push-buttons.

## Interface
- `NUM_ARMS`, 2: number of vehicle approaches; legal values are 2–4.
- `RA_TICKS`, 1: red+amber phase length, in clock cycles; must be ≥1.
- `GREEN_TICKS`, 4: green phase length; must be ≥1.
- `AMBER_TICKS`, 2: amber phase length; must be ≥1.
- `ALLRED_TICKS`, 1: all-red clearance length after each amber; must be ≥1.
- `WALK_TICKS`, 4: pedestrian walk length; must be ≥1.
- `FLASH_TICKS`, 2: pedestrian flash length; only used with the flash macro; must be ≥1.
- `clock` input 1: system clock; rising edge.
- `reset` input 1: asynchronous reset, active-low.
- `start` input 1: leaves IDLE when sampled high; ignored in every other state.
- `ped_request` input 1: pedestrian demand; level-sampled every cycle.
- `ped_wait` output 1: pedestrian request pending (the WAIT lamp).
- `lightseq` output 3*NUM_ARMS+2: lamp drives.
  - Arm i: `[3i+2:3i]` = {red, amber, green}.
  - Pedestrian: `[3N+1:3N]` = {ped_red, ped_green}, where N = `NUM_ARMS`.

## Operation
- States: IDLE, RED_AMBER, GREEN, AMBER, ALL_RED, PED_WALK, PED_FLASH (flash only with the macro).
  - `arm` register, width `$clog2(NUM_ARMS)`, selects the active approach.
- IDLE: every arm red, ped_red; `arm`=0.
  - `start`=1 → RED_AMBER.
- RED_AMBER → GREEN → AMBER → ALL_RED. Each phase lasts exactly its `*_TICKS` cycles.
- ALL_RED expiry:
  - If `ped_pending`=1 → PED_WALK.
  - Otherwise `arm` advances modulo NUM_ARMS (wraps NUM_ARMS−1→0) → RED_AMBER.
- PED_WALK, all cars red, ped_green=1, for `WALK_TICKS` cycles.
  - Then PED_FLASH if the macro is enabled; otherwise `arm` advances → RED_AMBER.
- Lamp states:
  - Only the active arm ever shows anything other than red.
  - RED_AMBER = 3'b110, GREEN = 3'b001, AMBER = 3'b010.
  - Inactive arms, and every arm in ALL_RED, PED_* and IDLE, show 3'b100.
- `ped_red` = ~`ped_green` at all times.
- `ped_pending`:
  - Set on any cycle with `ped_request`=1 while the state is not PED_WALK or PED_FLASH.
  - Cleared on entry to PED_WALK.
  - Requests made during PED_WALK/PED_FLASH are discarded.
  - Set and clear in the same cycle (the ALL_RED→PED_WALK edge): clear wins.
- `ped_wait` = `ped_pending`.
- Phase timer:
  - Down-counter, width `$clog2(max TICKS)+1`.
  - Loads TICKS−1 on state entry; the transition fires on the cycle it reads 0.
- Reset mid-operation: asynchronously returns to IDLE.
  - `arm`=0, `ped_pending`=0, timer=0.
  - Pending requests are lost.

## Timing
- All outputs are registered, Moore style: `lightseq` reflects a new state in the same cycle the state register updates.
- Reset values:
  - `lightseq` = every arm 3'b100, ped {1,0}.
  - `ped_wait` = 0.
- `start` high at edge k → RED_AMBER at edge k+1.
- `ped_request` high at edge k → `ped_wait`=1 after edge k+1.
- Phase of length T occupies exactly T consecutive cycles.
- Cycle time without pedestrians: NUM_ARMS × (RA+GREEN+AMBER+ALLRED) cycles.
- A pedestrian service inserts WALK (+FLASH) cycles after the ALL_RED that follows the request.

## Configuration
- `TRAFFIC_PED_FLASH_EN`:
  - Defined: PED_FLASH state is present. It lasts `FLASH_TICKS` cycles, cars stay red, and ped_green toggles every cycle starting at 0; ped_red = ~ped_green.
  - Undefined: the PED_FLASH state and its logic are absent, and PED_WALK exits directly to RED_AMBER.

## Structure
- `traffic_light_pkg`:
  - State enum.
  - Lamp encodings (LAMP_RED=3'b100, LAMP_RA=3'b110, LAMP_GREEN=3'b001, LAMP_AMBER=3'b010).
  - Field width constant 3.
- Sub-module `phase_timer`:
  - Parametrised width.
  - Inputs: `load`, `load_value`.
  - Output: `expired`.

## Test plan
Parameters: NUM_ARMS=2, RA=1, GREEN=3, AMBER=2, ALLRED=1, WALK=4, FLASH=2.
- Reset held, `start`=0 for 5 cycles → `lightseq`=8'b10_100_100, `ped_wait`=0, state stays IDLE.
- `start` pulse → arm0 sequence 110,001×3,010×2,100 over 7 cycles, then arm1 same, then arm0 again (wrap) at cycle 15.
- `ped_request` pulse during arm0 GREEN:
  - `ped_wait`=1 next cycle.
  - After ALL_RED, 4 cycles ped_green=1 with both arms 100; `ped_wait`=0 on walk entry.
  - Then arm1 RED_AMBER.
- Request during PED_WALK → `ped_wait` stays 0 and no second walk occurs.
- `reset` low mid-GREEN → `lightseq` returns to reset value asynchronously; after release, `start` restarts at arm0.
- With `TRAFFIC_PED_FLASH_EN`: after WALK, ped_green reads 0,1 over 2 cycles, then RED_AMBER on the next arm.
